clb_ecb_feeder: RTL and testbench

CLB_ECB_FEEDER -- requirements
Module: clb_ecb_feeder

---
 rtl/clb_ecb_feeder.sv | 121 ++++++++++++
 tb/tb_clb_ecb_feeder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clb_ecb_feeder.sv
// Packs four 32-bit words into a 128-bit block, runs the attached ECB cipher core and holds the result.
// Optional RUN-state timeout with err pulse is built when CLB_FEEDER_TIMEOUT_EN is defined.
module clb_ecb_feeder #(
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  output logic [127:0] core_textin,
  output logic [127:0] core_key,
  output logic         core_rst_n,
  input  logic [127:0] core_textout,
  input  logic         core_enable,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);

  typedef enum logic [1:0] {COLLECT, LOAD, RUN, HOLD} state_e;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [127:0]    textin_q, textin_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    out_data_q, out_data_d;
`ifdef CLB_FEEDER_TIMEOUT_EN
  logic            err_q, err_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    cyc_d      = cyc_q;
    textin_d   = textin_q;
    key_d      = key_q;
    out_data_d = out_data_q;
`ifdef CLB_FEEDER_TIMEOUT_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          // Word 0 lands in bits 127:96, word 3 in bits 31:0.
          textin_d[{~wcnt_q, 5'd0} +: 32] = in_data;
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) state_d = LOAD;
        end
      end
      LOAD: begin
        key_d   = key;
        cyc_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (core_enable) begin
          out_data_d = core_textout;
          state_d    = HOLD;
        end else begin
`ifdef CLB_FEEDER_TIMEOUT_EN
          if (cyc_q == CW'(TIMEOUT - 1)) begin
            state_d = COLLECT;
            err_d   = 1'b1;
          end
`endif
          if (cyc_q != {CW{1'b1}}) cyc_d = cyc_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    if (rst) begin
      state_q    <= COLLECT;
      wcnt_q     <= '0;
      cyc_q      <= '0;
      textin_q   <= '0;
      key_q      <= '0;
      out_data_q <= '0;
`ifdef CLB_FEEDER_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      cyc_q      <= cyc_d;
      textin_q   <= textin_d;
      key_q      <= key_d;
      out_data_q <= out_data_d;
`ifdef CLB_FEEDER_TIMEOUT_EN
      err_q      <= err_d;
`endif
    end
  end

  // Handshake and core control are pure decodes of the state register.
  assign in_ready    = (state_q == COLLECT);
  assign core_rst_n  = (state_q == RUN);
  assign out_valid   = (state_q == HOLD);
  assign core_textin = textin_q;
  assign core_key    = key_q;
  assign out_data    = out_data_q;
`ifdef CLB_FEEDER_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_clb_ecb_feeder.sv
// Directed bench for clb_ecb_feeder with a behavioural cipher core that strobes in its 21st enabled cycle.
module tb_clb_ecb_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] core_textin;
  logic [127:0] core_key;
  logic         core_rst_n;
  logic [127:0] core_textout;
  logic         core_enable;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] MASK = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;

  clb_ecb_feeder #(.TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .core_textin(core_textin), .core_key(core_key), .core_rst_n(core_rst_n),
    .core_textout(core_textout), .core_enable(core_enable), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural core: cleared while core_rst_n is low, strobes when its counter reads 20.
  logic       core_on;
  logic [4:0] core_cnt;
  always @(posedge clk) begin
    if (!core_rst_n) core_cnt <= 5'd0;
    else if (core_cnt != 5'd31) core_cnt <= core_cnt + 5'd1;
  end
  assign core_enable  = core_on && core_rst_n && (core_cnt == 5'd20);
  assign core_textout = core_textin ^ core_key ^ MASK;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Feeds four words; leaves the DUT in LOAD (the cycle after the 4th accept).
  task automatic send_words(input logic [31:0] w0, w1, w2, w3, input bit toggle);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      tick();
      if (toggle && i < 3) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        tick();
      end
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  // Checks LOAD contents, RUN entry, 22-edge latency and result; leaves the DUT in HOLD.
  task automatic run_block(input string tag, input logic [127:0] exp_text, input logic [127:0] k);
    int n;
    check({tag, " load textin"}, core_textin, exp_text);
    check({tag, " load in_ready"}, 128'(in_ready), 128'(0));
    check({tag, " load core_rst_n"}, 128'(core_rst_n), 128'(0));
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
      if (n == 1) begin
        check({tag, " run core_key"}, core_key, k);
        check({tag, " run core_rst_n"}, 128'(core_rst_n), 128'(1));
      end
    end
    check({tag, " latency"}, 128'(n + 1), 128'(22 + 1));
    check({tag, " out_data"}, out_data, exp_text ^ k ^ MASK);
  endtask

  task automatic release_hold(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " release in_ready"}, 128'(in_ready), 128'(1));
    check({tag, " release out_valid"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] ka, kb, kc, exp_a, held;
    int err_cnt, err_at, ov_seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; key = '0; out_ready = 1'b0; core_on = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset in_ready", 128'(in_ready), 128'(1));
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset err", 128'(err), 128'(0));
    check("reset core_rst_n", 128'(core_rst_n), 128'(0));
    check("reset core_textin", core_textin, 128'(0));
    check("reset core_key", core_key, 128'(0));
    check("reset out_data", out_data, 128'(0));

    // Block A: back-to-back words, then a 10-cycle stall in HOLD.
    ka = 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C;
    key = ka;
    send_words(32'h0001_0203, 32'h0405_0607, 32'h0809_0A0B, 32'h0C0D_0E0F, 1'b0);
    exp_a = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
    run_block("A", exp_a, ka);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("A stall out_valid", 128'(out_valid), 128'(1));
      check("A stall out_data", out_data, exp_a ^ ka ^ MASK);
      check("A stall in_ready", 128'(in_ready), 128'(0));
    end
    release_hold("A");

    // Block B: in_valid toggles every cycle; only the valid beats may be packed.
    kb = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    key = kb;
    send_words(32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004, 1'b1);
    run_block("B", 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004, kb);
    release_hold("B");

    // Block C: reset at RUN cycle 10 discards everything.
    kc = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
    key = kc;
    send_words(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("C run before reset", 128'(core_rst_n), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("C rst core_rst_n", 128'(core_rst_n), 128'(0));
    check("C rst out_valid", 128'(out_valid), 128'(0));
    check("C rst in_ready", 128'(in_ready), 128'(1));
    check("C rst core_textin", core_textin, 128'(0));
    check("C rst out_data", out_data, 128'(0));

    // Block D: a fresh block after the reset completes normally.
    send_words(32'h0F1E_2D3C, 32'h4B5A_6978, 32'h8796_A5B4, 32'hC3D2_E1F0, 1'b0);
    run_block("D", 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, kc);
    held = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0 ^ kc ^ MASK;
    release_hold("D");

    // Block E: the core never answers.
    core_on = 1'b0;
    send_words(32'h5555_0000, 32'h5555_1111, 32'h5555_2222, 32'h5555_3333, 1'b0);
    err_cnt = 0; err_at = 0; ov_seen = 0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (err) begin
        err_cnt++;
        err_at = n;
      end
      if (out_valid) ov_seen = 1;
    end
`ifdef CLB_FEEDER_TIMEOUT_EN
    check("E err pulses", 128'(err_cnt), 128'(1));
    check("E err edge", 128'(err_at), 128'(33));
    check("E back to collect", 128'(in_ready), 128'(1));
    check("E out_data kept", out_data, held);
`else
    check("E err tied low", 128'(err_cnt), 128'(0));
    check("E still running", 128'(core_rst_n), 128'(1));
    check("E out_data kept", out_data, held);
`endif
    check("E no out_valid", 128'(ov_seen), 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_on = 1'b1;
    check("E recover in_ready", 128'(in_ready), 128'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
